// File: rtl/time_keeper.sv
// time_keeper: BCD hours/minutes/seconds time-of-day counter with a
// two-button set FSM (RUN -> SET_HOUR -> SET_MIN -> RUN), a set-mode
// inactivity timeout and a per-digit blink mask for the display driver.
// Optional build macro: TWELVE_HOUR_EN selects 12 h counting (12,01..11
// with a PM flag); when undefined the counter runs 00..23 and pm_o is 0.
module time_keeper #(
  parameter int unsigned SET_TIMEOUT_S = 30
) (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       tick_1hz_i,
  input  logic       blink_i,
  input  logic       btn_mode_i,
  input  logic       btn_inc_i,
  output logic [1:0] hour_tens_o,
  output logic [3:0] hour_ones_o,
  output logic [2:0] min_tens_o,
  output logic [3:0] min_ones_o,
  output logic [2:0] sec_tens_o,
  output logic [3:0] sec_ones_o,
  output logic [5:0] digit_blank_o,
  output logic [1:0] mode_o,
  output logic       pm_o,
  output logic       carry_day_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } state_t;

`ifdef TWELVE_HOUR_EN
  localparam logic [1:0] HOUR_TENS_RST = 2'd1;
  localparam logic [3:0] HOUR_ONES_RST = 4'd2;
`else
  localparam logic [1:0] HOUR_TENS_RST = 2'd0;
  localparam logic [3:0] HOUR_ONES_RST = 4'd0;
`endif

  localparam logic [7:0] TIMEOUT_LAST = 8'(SET_TIMEOUT_S - 32'd1);

  // Modulo-60 BCD increment; returns {carry, tens, ones}. Out-of-range
  // digits fold back into the legal range instead of propagating.
  function automatic logic [7:0] inc_bcd60(input logic [2:0] tens, input logic [3:0] ones);
    logic [7:0] res;
    if (ones >= 4'd9) begin
      if (tens >= 3'd5) res = {1'b1, 3'd0, 4'd0};
      else              res = {1'b0, tens + 3'd1, 4'd0};
    end else begin
      res = {1'b0, tens, ones + 4'd1};
    end
    return res;
  endfunction

  // Hour increment; returns {flag, tens, ones}. In the 12 h build the flag
  // marks the 11 -> 12 step (AM/PM flips); in 24 h it marks 23 -> 00.
  function automatic logic [6:0] inc_hour(input logic [1:0] tens, input logic [3:0] ones);
    logic [6:0] res;
`ifdef TWELVE_HOUR_EN
    if ((tens >= 2'd2) || ((tens == 2'd1) && (ones >= 4'd2))) res = {1'b0, 2'd0, 4'd1};
    else if ((tens == 2'd1) && (ones == 4'd1))                 res = {1'b1, 2'd1, 4'd2};
    else if (ones >= 4'd9)                                     res = {1'b0, 2'd1, 4'd0};
    else                                                       res = {1'b0, tens, ones + 4'd1};
`else
    if ((tens >= 2'd2) && (ones >= 4'd3)) res = {1'b1, 2'd0, 4'd0};
    else if (ones >= 4'd9)                res = {1'b0, tens + 2'd1, 4'd0};
    else                                  res = {1'b0, tens, ones + 4'd1};
`endif
    return res;
  endfunction

  state_t     state_r, state_n;
  logic [7:0] cnt_r, cnt_n;
  logic [1:0] hour_tens_r, hour_tens_n;
  logic [3:0] hour_ones_r, hour_ones_n;
  logic [2:0] min_tens_r, min_tens_n;
  logic [3:0] min_ones_r, min_ones_n;
  logic [2:0] sec_tens_r, sec_tens_n;
  logic [3:0] sec_ones_r, sec_ones_n;
  logic       pm_r, pm_n;
  logic       carry_r, carry_n;
  logic [5:0] blank_r, blank_n;

  logic [7:0] sec_inc_s;
  logic [7:0] min_inc_s;
  logic [6:0] hour_inc_s;
  logic       timeout_s;

  assign sec_inc_s  = inc_bcd60(sec_tens_r, sec_ones_r);
  assign min_inc_s  = inc_bcd60(min_tens_r, min_ones_r);
  assign hour_inc_s = inc_hour(hour_tens_r, hour_ones_r);
  assign timeout_s  = tick_1hz_i && (cnt_r == TIMEOUT_LAST);

  // Next-state, time and mask computation; button beats tick/timeout.
  always_comb begin
    state_n     = state_r;
    cnt_n       = cnt_r;
    hour_tens_n = hour_tens_r;
    hour_ones_n = hour_ones_r;
    min_tens_n  = min_tens_r;
    min_ones_n  = min_ones_r;
    sec_tens_n  = sec_tens_r;
    sec_ones_n  = sec_ones_r;
    pm_n        = pm_r;
    carry_n     = 1'b0;
    blank_n     = 6'b000000;
    case (state_r)
      RUN: begin
        if (tick_1hz_i) begin
          sec_tens_n = sec_inc_s[6:4];
          sec_ones_n = sec_inc_s[3:0];
          if (sec_inc_s[7]) begin
            min_tens_n = min_inc_s[6:4];
            min_ones_n = min_inc_s[3:0];
            if (min_inc_s[7]) begin
              hour_tens_n = hour_inc_s[5:4];
              hour_ones_n = hour_inc_s[3:0];
`ifdef TWELVE_HOUR_EN
              pm_n    = pm_r ^ hour_inc_s[6];
              carry_n = pm_r & hour_inc_s[6];
`else
              carry_n = hour_inc_s[6];
`endif
            end else begin
              carry_n = 1'b0;
            end
          end else begin
            carry_n = 1'b0;
          end
        end else begin
          carry_n = 1'b0;
        end
        if (btn_mode_i) begin
          state_n = SET_HOUR;
          cnt_n   = 8'd0;
        end else begin
          state_n = RUN;
        end
      end
      SET_HOUR: begin
        if (btn_mode_i) begin
          state_n = SET_MIN;
          cnt_n   = 8'd0;
        end else if (btn_inc_i) begin
          hour_tens_n = hour_inc_s[5:4];
          hour_ones_n = hour_inc_s[3:0];
`ifdef TWELVE_HOUR_EN
          pm_n = pm_r ^ hour_inc_s[6];
`endif
          cnt_n = 8'd0;
        end else if (timeout_s) begin
          state_n    = RUN;
          cnt_n      = 8'd0;
          sec_tens_n = 3'd0;
          sec_ones_n = 4'd0;
        end else if (tick_1hz_i) begin
          cnt_n = cnt_r + 8'd1;
        end else begin
          cnt_n = cnt_r;
        end
      end
      SET_MIN: begin
        if (btn_mode_i || timeout_s) begin
          state_n    = RUN;
          cnt_n      = 8'd0;
          sec_tens_n = 3'd0;
          sec_ones_n = 4'd0;
        end else if (btn_inc_i) begin
          min_tens_n = min_inc_s[6:4];
          min_ones_n = min_inc_s[3:0];
          cnt_n      = 8'd0;
        end else if (tick_1hz_i) begin
          cnt_n = cnt_r + 8'd1;
        end else begin
          cnt_n = cnt_r;
        end
      end
      default: begin
        state_n = RUN;
        cnt_n   = 8'd0;
      end
    endcase
    case (state_n)
      SET_HOUR: blank_n = {{2{blink_i}}, 4'b0000};
      SET_MIN:  blank_n = {2'b00, {2{blink_i}}, 2'b00};
      default:  blank_n = 6'b000000;
    endcase
  end

  // State, time and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= RUN;
      cnt_r       <= 8'd0;
      hour_tens_r <= HOUR_TENS_RST;
      hour_ones_r <= HOUR_ONES_RST;
      min_tens_r  <= 3'd0;
      min_ones_r  <= 4'd0;
      sec_tens_r  <= 3'd0;
      sec_ones_r  <= 4'd0;
      pm_r        <= 1'b0;
      carry_r     <= 1'b0;
      blank_r     <= 6'b000000;
    end else begin
      state_r     <= state_n;
      cnt_r       <= cnt_n;
      hour_tens_r <= hour_tens_n;
      hour_ones_r <= hour_ones_n;
      min_tens_r  <= min_tens_n;
      min_ones_r  <= min_ones_n;
      sec_tens_r  <= sec_tens_n;
      sec_ones_r  <= sec_ones_n;
      pm_r        <= pm_n;
      carry_r     <= carry_n;
      blank_r     <= blank_n;
    end
  end

  assign hour_tens_o   = hour_tens_r;
  assign hour_ones_o   = hour_ones_r;
  assign min_tens_o    = min_tens_r;
  assign min_ones_o    = min_ones_r;
  assign sec_tens_o    = sec_tens_r;
  assign sec_ones_o    = sec_ones_r;
  assign digit_blank_o = blank_r;
  assign mode_o        = state_r;
  assign pm_o          = pm_r;
  assign carry_day_o   = carry_r;

endmodule

// File: tb/tb_time_keeper.sv
// Testbench for time_keeper: table of vectors plus hand-written sequences;
// expected results are queued when stimulus is applied and compared once
// the registered outputs are available.
module tb_time_keeper;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       tick_1hz_i = 1'b0;
  logic       blink_i = 1'b0;
  logic       btn_mode_i = 1'b0;
  logic       btn_inc_i = 1'b0;
  logic [1:0] hour_tens_o;
  logic [3:0] hour_ones_o;
  logic [2:0] min_tens_o;
  logic [3:0] min_ones_o;
  logic [2:0] sec_tens_o;
  logic [3:0] sec_ones_o;
  logic [5:0] digit_blank_o;
  logic [1:0] mode_o;
  logic       pm_o;
  logic       carry_day_o;

  int errors = 0;
  int checks = 0;

  time_keeper #(.SET_TIMEOUT_S(30)) dut (
    .clk(clk), .rst_i(rst_i), .tick_1hz_i(tick_1hz_i), .blink_i(blink_i),
    .btn_mode_i(btn_mode_i), .btn_inc_i(btn_inc_i),
    .hour_tens_o(hour_tens_o), .hour_ones_o(hour_ones_o),
    .min_tens_o(min_tens_o), .min_ones_o(min_ones_o),
    .sec_tens_o(sec_tens_o), .sec_ones_o(sec_ones_o),
    .digit_blank_o(digit_blank_o), .mode_o(mode_o), .pm_o(pm_o),
    .carry_day_o(carry_day_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         full;
    logic [19:0] t;
    int         h, mi, s;
    logic [1:0] md;
    logic [5:0] bl;
    logic       cd;
    logic       pm;
  } exp_t;

  typedef struct {
    bit   tk, md, ic, bl;
    exp_t e;
  } vec_t;

  exp_t sb_q[$];

  function automatic exp_t X(input string nm, input int h, input int mi, input int s,
                             input logic [1:0] md, input logic [5:0] bl,
                             input logic cd, input logic pm);
    exp_t e;
    e.name = nm; e.full = 1'b1; e.h = h; e.mi = mi; e.s = s;
    e.t = {2'(h / 10), 4'(h % 10), 3'(mi / 10), 4'(mi % 10), 3'(s / 10), 4'(s % 10)};
    e.md = md; e.bl = bl; e.cd = cd; e.pm = pm;
    return e;
  endfunction

  function automatic exp_t C0(input string nm);
    exp_t e;
    e = X(nm, 0, 0, 0, 2'd0, 6'd0, 1'b0, 1'b0);
    e.full = 1'b0;
    return e;
  endfunction

  task automatic check_now(input exp_t e);
    logic [19:0] got_t;
    got_t = {hour_tens_o, hour_ones_o, min_tens_o, min_ones_o, sec_tens_o, sec_ones_o};
    checks++;
    if (carry_day_o !== e.cd) begin
      errors++;
      $display("FAIL %s carry_day: got %0b want %0b", e.name, carry_day_o, e.cd);
    end
    if (e.full) begin
      checks++;
      if (got_t !== e.t) begin
        errors++;
        $display("FAIL %s time: got %0d%0d:%0d%0d:%0d%0d want %02d:%02d:%02d", e.name,
                 hour_tens_o, hour_ones_o, min_tens_o, min_ones_o, sec_tens_o, sec_ones_o,
                 e.h, e.mi, e.s);
      end
      checks++;
      if (mode_o !== e.md) begin
        errors++;
        $display("FAIL %s mode: got %0d want %0d", e.name, mode_o, e.md);
      end
      checks++;
      if (digit_blank_o !== e.bl) begin
        errors++;
        $display("FAIL %s blank: got %b want %b", e.name, digit_blank_o, e.bl);
      end
      checks++;
      if (pm_o !== e.pm) begin
        errors++;
        $display("FAIL %s pm: got %0b want %0b", e.name, pm_o, e.pm);
      end
    end
  endtask

  // Drive one cycle of stimulus (called at a falling edge), queue the
  // expectation, then compare at the next falling edge.
  task automatic step(input bit tk, input bit md, input bit ic, input bit bl, input exp_t e);
    exp_t got;
    tick_1hz_i = tk; btn_mode_i = md; btn_inc_i = ic; blink_i = bl;
    sb_q.push_back(e);
    @(negedge clk);
    tick_1hz_i = 1'b0; btn_mode_i = 1'b0; btn_inc_i = 1'b0;
    got = sb_q.pop_front();
    check_now(got);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, X("tick_235959", 23, 59, 59, 2'd0, 6'd0, 1'b0, 1'b0)};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, X("midnight", 0, 0, 0, 2'd0, 6'd0, 1'b1, 1'b0)};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, X("carry_one_cycle", 0, 0, 0, 2'd0, 6'd0, 1'b0, 1'b0)};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, X("inc_in_run", 0, 0, 0, 2'd0, 6'd0, 1'b0, 1'b0)};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, X("tick_inc_run", 0, 0, 1, 2'd0, 6'd0, 1'b0, 1'b0)};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, X("tick_run", 0, 0, 2, 2'd0, 6'd0, 1'b0, 1'b0)};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, X("enter_set_hour", 0, 0, 2, 2'd1, 6'd0, 1'b0, 1'b0)};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, X("tick_frozen", 0, 0, 2, 2'd1, 6'd0, 1'b0, 1'b0)};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, X("blink_hour", 0, 0, 2, 2'd1, 6'b110000, 1'b0, 1'b0)};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, X("mode_beats_inc", 0, 0, 2, 2'd2, 6'b001100, 1'b0, 1'b0)};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b0, X("inc_min", 0, 1, 2, 2'd2, 6'd0, 1'b0, 1'b0)};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, X("tick_mode_exit", 0, 1, 0, 2'd0, 6'd0, 1'b0, 1'b0)};

    repeat (3) @(negedge clk);
`ifdef TWELVE_HOUR_EN
    check_now(X("reset", 12, 0, 0, 2'd0, 6'd0, 1'b0, 1'b0));
    rst_i = 1'b0;
    @(negedge clk);
    step(0, 1, 0, 0, X("h12_set_hour", 12, 0, 0, 2'd1, 6'd0, 1'b0, 1'b0));
    repeat (11) step(0, 0, 1, 0, C0("h12_inc"));
    step(0, 1, 0, 0, X("h12_set_min", 11, 0, 0, 2'd2, 6'd0, 1'b0, 1'b0));
    repeat (59) step(0, 0, 1, 0, C0("h12_inc_min"));
    step(0, 1, 0, 0, X("h12_run", 11, 59, 0, 2'd0, 6'd0, 1'b0, 1'b0));
    repeat (59) step(1, 0, 0, 0, C0("h12_ticks"));
    step(0, 0, 0, 0, X("h12_115959am", 11, 59, 59, 2'd0, 6'd0, 1'b0, 1'b0));
    step(1, 0, 0, 0, X("h12_noon", 12, 0, 0, 2'd0, 6'd0, 1'b0, 1'b1));
    step(0, 1, 0, 0, X("h12_set_hour_pm", 12, 0, 0, 2'd1, 6'd0, 1'b0, 1'b1));
    repeat (11) step(0, 0, 1, 0, C0("h12_inc_pm"));
    step(0, 1, 0, 0, X("h12_11pm", 11, 0, 0, 2'd2, 6'd0, 1'b0, 1'b1));
    repeat (59) step(0, 0, 1, 0, C0("h12_inc_min_pm"));
    step(0, 1, 0, 0, X("h12_run_pm", 11, 59, 0, 2'd0, 6'd0, 1'b0, 1'b1));
    repeat (59) step(1, 0, 0, 0, C0("h12_ticks_pm"));
    step(1, 0, 0, 0, X("h12_midnight", 12, 0, 0, 2'd0, 6'd0, 1'b1, 1'b0));
`else
    check_now(X("reset", 0, 0, 0, 2'd0, 6'd0, 1'b0, 1'b0));
    rst_i = 1'b0;
    @(negedge clk);
    // Long run: 3661 s from midnight.
    repeat (3661) step(1, 0, 0, 0, C0("run_no_carry"));
    step(0, 0, 0, 0, X("run_3661", 1, 1, 1, 2'd0, 6'd0, 1'b0, 1'b0));
    // Preload 23:59 via the set mode, including minute wrap without hour carry.
    step(0, 1, 0, 0, X("pre_set_hour", 1, 1, 1, 2'd1, 6'd0, 1'b0, 1'b0));
    repeat (22) step(0, 0, 1, 0, C0("pre_inc_hour"));
    step(0, 1, 0, 0, X("pre_set_min", 23, 1, 1, 2'd2, 6'd0, 1'b0, 1'b0));
    repeat (58) step(0, 0, 1, 0, C0("pre_inc_min"));
    step(0, 0, 0, 0, X("pre_min59", 23, 59, 1, 2'd2, 6'd0, 1'b0, 1'b0));
    step(0, 0, 1, 0, X("min_wrap", 23, 0, 1, 2'd2, 6'd0, 1'b0, 1'b0));
    repeat (59) step(0, 0, 1, 0, C0("pre_inc_min2"));
    step(0, 1, 0, 0, X("pre_exit_sec_clr", 23, 59, 0, 2'd0, 6'd0, 1'b0, 1'b0));
    repeat (58) step(1, 0, 0, 0, C0("pre_ticks"));
    step(0, 0, 0, 0, X("pre_235958", 23, 59, 58, 2'd0, 6'd0, 1'b0, 1'b0));
    for (int i = 0; i < 12; i++) step(tbl[i].tk, tbl[i].md, tbl[i].ic, tbl[i].bl, tbl[i].e);
    // 25 hour increments with wrap, ticks frozen.
    repeat (5) step(1, 0, 0, 0, C0("ticks5"));
    step(0, 1, 0, 0, X("sh_enter", 0, 1, 5, 2'd1, 6'd0, 1'b0, 1'b0));
    step(1, 0, 0, 0, X("sh_tick", 0, 1, 5, 2'd1, 6'd0, 1'b0, 1'b0));
    repeat (25) step(0, 0, 1, 0, C0("sh_inc_no_carry"));
    step(0, 0, 0, 0, X("sh_inc25", 1, 1, 5, 2'd1, 6'd0, 1'b0, 1'b0));
    step(1, 0, 0, 0, X("sh_tick2", 1, 1, 5, 2'd1, 6'd0, 1'b0, 1'b0));
    step(0, 1, 1, 0, X("sh_mode_inc", 1, 1, 5, 2'd2, 6'd0, 1'b0, 1'b0));
    // SET_MIN timeout with blink tracking.
    for (int i = 1; i <= 30; i++) begin
      bit b;
      b = (i % 2) == 1;
      if (i < 30) step(1, 0, 0, b, X("sm_blink", 1, 1, 5, 2'd2, {2'b00, b, b, 2'b00}, 1'b0, 1'b0));
      else        step(1, 0, 0, b, X("sm_timeout", 1, 1, 0, 2'd0, 6'd0, 1'b0, 1'b0));
    end
    step(0, 0, 0, 1, X("run_blank_off", 1, 1, 0, 2'd0, 6'd0, 1'b0, 1'b0));
    // Button beats timeout, then timeout out of SET_HOUR.
    repeat (3) step(1, 0, 0, 0, C0("ticks3"));
    step(0, 1, 0, 0, X("to_enter", 1, 1, 3, 2'd1, 6'd0, 1'b0, 1'b0));
    repeat (29) step(1, 0, 0, 0, C0("to_ticks"));
    step(0, 0, 0, 0, X("to_29", 1, 1, 3, 2'd1, 6'd0, 1'b0, 1'b0));
    step(1, 0, 1, 0, X("inc_beats_timeout", 2, 1, 3, 2'd1, 6'd0, 1'b0, 1'b0));
    repeat (29) step(1, 0, 0, 0, C0("to_ticks2"));
    step(0, 0, 0, 0, X("to_29b", 2, 1, 3, 2'd1, 6'd0, 1'b0, 1'b0));
    step(1, 0, 0, 0, X("sh_timeout", 2, 1, 0, 2'd0, 6'd0, 1'b0, 1'b0));
    // Reset mid-edit.
    step(0, 1, 0, 0, X("rst_enter", 2, 1, 0, 2'd1, 6'd0, 1'b0, 1'b0));
    step(0, 0, 1, 1, X("rst_inc", 3, 1, 0, 2'd1, 6'b110000, 1'b0, 1'b0));
    rst_i = 1'b1;
    #1;
    check_now(X("rst_mid_edit", 0, 0, 0, 2'd0, 6'd0, 1'b0, 1'b0));
    @(negedge clk);
    rst_i = 1'b0;
    step(0, 0, 0, 0, X("post_rst", 0, 0, 0, 2'd0, 6'd0, 1'b0, 1'b0));
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/time_keeper.md
# time_keeper

Hours/minutes/seconds BCD time-of-day counter for the digital clock, directly downstream of the clock divider. Consumes the divider's 1 Hz single-cycle pulse to advance time and its 500 ms toggle to blink the field under edit. Provides a two-button set FSM and per-digit values plus a blank mask for the display driver.

## Interface
- SET_TIMEOUT_S, default 30: seconds without a button press in a set state before returning to RUN; legal range 1..255.

- clk  in  1  system clock, 100 MHz
- rst_i  in  1  asynchronous, active-high reset
- tick_1hz_i  in  1  single-cycle pulse, once per second, from the clock divider
- blink_i  in  1  500 ms toggle level from the clock divider
- btn_mode_i  in  1  debounced single-cycle pulse: advance edit mode
- btn_inc_i  in  1  debounced single-cycle pulse: increment field under edit
- hour_tens_o  out  2  BCD hour tens
- hour_ones_o  out  4  BCD hour ones
- min_tens_o  out  3  BCD minute tens
- min_ones_o  out  4  BCD minute ones
- sec_tens_o  out  3  BCD second tens
- sec_ones_o  out  4  BCD second ones
- digit_blank_o  out  6  blank mask, 1 = blank; bits [5:4] hour tens/ones, [3:2] minute, [1:0] second
- mode_o  out  2  0 = RUN, 1 = SET_HOUR, 2 = SET_MIN
- pm_o  out  1  PM indicator (12 h build only, else 0)
- carry_day_o  out  1  single-cycle pulse on midnight rollover

## Operation
- FSM states: RUN, SET_HOUR, SET_MIN. btn_mode_i: RUN→SET_HOUR→SET_MIN→RUN.
- RUN: each tick_1hz_i advances seconds by one. Cascaded BCD carries: sec 59→00 carries to min, min 59→00 carries to hour, hour 23→00 raises carry_day_o. btn_inc_i ignored.
- SET_HOUR: btn_inc_i increments hour, 23→00 wrap, no carry_day_o, minutes untouched. SET_MIN: btn_inc_i increments minute, 59→00 wrap, no hour carry.
- In both set states tick_1hz_i does not advance time. It increments an 8-bit timeout counter instead.
- The timeout counter clears on any button pulse and on every state entry. When it reaches SET_TIMEOUT_S, the FSM goes to RUN.
- Seconds clear to 00 on every transition into RUN from a set state, whether by button or by timeout.
- Blink: in SET_HOUR, digit_blank_o[5:4] = {2{blink_i}}; in SET_MIN, digit_blank_o[3:2] = {2{blink_i}}. All other bits 0. In RUN, the whole mask is 0.
- Simultaneous events:
  - btn_mode_i and btn_inc_i in the same cycle: mode wins, inc discarded.
  - Button and timeout in the same cycle: the button wins and the timeout is discarded.
  - tick_1hz_i coincident with a btn_mode_i exit to RUN: seconds clear and the tick is not applied.
- Every BCD digit stays within its legal range at all times. No illegal encodings are ever produced.

## Timing
- Reset values: all digits 0 (00:00:00), mode_o 0, digit_blank_o 0, pm_o 0, carry_day_o 0, timeout counter 0. The 12 h build resets to 12:00:00 with pm_o 0.
- All outputs are registered. A tick or button sampled at edge N is visible at edge N+1.
- carry_day_o is high for exactly the cycle in which the digits first read 00:00:00 (12:00:00 AM in the 12 h build).
- digit_blank_o follows blink_i with one cycle of latency.
- rst_i asserted mid-edit aborts the edit immediately and restores all reset values. There is no clock requirement during reset.

## Configuration
- TWELVE_HOUR_EN defined: hours count 12,01..11. pm_o toggles on the 11→12 transition, both in RUN and in SET_HOUR. SET_HOUR walks all 24 hour/AM-PM combinations, and incrementing from 11 PM gives 12 AM with no carry_day_o. In RUN, 11:59:59 PM → 12:00:00 AM raises carry_day_o.
- TWELVE_HOUR_EN undefined: 24 h counting 00..23 as described above; pm_o tied 0.

## Test plan
- Reset, then 3661 ticks in RUN → digits read 01:01:01. No carry_day_o.
- Preload 23:59:58 via the set mode, return to RUN, then 2 ticks → 00:00:00 on the second tick. carry_day_o is high for exactly 1 cycle.
- Enter SET_HOUR and give 25 inc pulses → hour 01. Minutes unchanged. Ticks during the edit do not change seconds.
- Enter SET_MIN, toggle blink_i, and wait 30 ticks with no buttons → mode_o returns to 0 and seconds read 00. digit_blank_o[3:2] tracked blink_i one cycle late until exit.
- btn_mode_i and btn_inc_i in the same cycle in SET_HOUR → enters SET_MIN and hour is unchanged. Assert rst_i mid-edit → 00:00:00, mode_o 0.
- With TWELVE_HOUR_EN: reset → 12:00:00 with pm_o 0. Advance to 11:59:59 and give 1 tick → 12:00:00 with pm_o 1.
